count_capture: RTL and testbench
================================

# count_capture

Timestamp capture unit placed directly downstream of the user-area counter: it consumes the free-running `count` bus and latches its value into a small FIFO on each qualifying edge of an external trigger pin taken from `io_in`. Firmware on the management SoC drains the timestamps over the Wishbone slave port and may take an interrupt when the FIFO fill level reaches a programmable threshold.

## Interface
- `BITS`, 32: width of `count` and of each captured timestamp.
- `DEPTH`, 8: FIFO entries; a power of two, from 2 to 64.
- `wb_clk_i` input 1: sole clock.
- `wb_rst_i` input 1: reset, synchronous, active-high.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` input 1 each: Wishbone strobe, cycle and write-enable.
- `wbs_sel_i` input 4: byte lanes, honoured on writes.
- `wbs_adr_i` input 32: only bits [3:2] are decoded.
- `wbs_dat_i` input 32: write data.
- `wbs_ack_o` output 1: acknowledge.
- `wbs_dat_o` output 32: read data.
- `count` input BITS: live counter value from the counter stage.
- `cap_in` input 1: asynchronous trigger pin.
- `irq` output 1: level interrupt.

## Operation
- `cap_in` passes through a 2-flop synchronizer (s1, s2), then a delay flop s3. A rising edge is s2 & !s3.
- While CTRL.enable = 1, each detected edge pushes the `count` value sampled in the same cycle.
- Register map, selected by `wbs_adr_i[3:2]`:
  - 0 DATA (RO): a read pops the FIFO head. Reading while empty returns 0, does not pop, and sets sticky `underflow`.
  - 1 STATUS (RO): [6:0] level; [16] empty; [17] full; [18] overflow (sticky); [19] underflow (sticky); [20] edge flag of the head entry (0 without the macro).
  - 2 CTRL (RW): [0] enable; [1] irq_en; [2] clear, self-clearing and always reads 0. Clear flushes the FIFO and both stickies.
  - 3 THRESH (RW): [6:0] threshold.
  - Writes to RO registers are acknowledged and ignored.
- FIFO boundary rules:
  - Push while full with no simultaneous pop: the entry is dropped and `overflow` is set.
  - Push and pop in the same cycle while full: both take effect, level is unchanged, no overflow.
  - Push and pop in the same cycle while empty: the push happens and the read returns 0 with `underflow` set. The new entry is not bypassed to the reader.
  - Clear overrides any push or pop in the same cycle.
- Pointers are log2(DEPTH)+1 bits and wrap naturally; level = wr_ptr − rd_ptr.
- `irq` is registered: irq = irq_en & ((THRESH != 0 & level >= THRESH) | overflow).

## Timing
- All outputs reset to 0. CTRL, THRESH, FIFO pointers, stickies and synchronizer flops also reset to 0.
- Wishbone handshake:
  - valid = cyc & stb.
  - `wbs_ack_o` rises in the cycle after valid is first seen, lasts exactly one cycle, and is not reasserted while ack = 1 (no back-to-back ack).
  - `wbs_dat_o` is registered and valid during ack; it holds its value otherwise.
  - Pop, register writes and clear all take effect on the ack edge.
- Capture latency: `cap_in` high at setup of edge N means `count` is sampled at edge N+2 and the entry is visible in STATUS.level from edge N+3.
- Minimum trigger pulse is 1 clock high plus 1 clock low between edges; shorter pulses may be missed.
- `irq` follows the level by one cycle.
- Reset asserted mid-transaction: ack drops next cycle and the FIFO empties. The master must restart the access.

## Configuration
- `COUNT_CAPTURE_BOTH_EDGES_EN`:
  - Defined: falling edges (!s2 & s3) also push. A per-entry edge flag (1 = rising) is stored alongside the timestamp and reported in STATUS[20].
  - Undefined: rising edges only, no flag storage, STATUS[20] reads 0.

## Structure
- Package `count_capture_pkg` holds:
  - register offsets (DATA, STATUS, CTRL, THRESH);
  - STATUS and CTRL bit-position constants;
  - level field width, fixed at 7.
- Sub-module `capture_fifo`: synchronous FIFO with registered pointers, full/empty/level outputs, push/pop/flush inputs, and width BITS (+1 with the macro). The top level holds the synchronizer, register file, Wishbone logic and irq.

## Test plan
- Reset, then read STATUS → 0x0001_0000 (empty). Read DATA → 0, after which STATUS[19] = 1.
- Enable; drive `count` = 0x100, incrementing by 1 per cycle; pulse `cap_in` at the cycle where `count` = 0x100 → DATA returns 0x102; level goes 1 → 0.
- Ten rising edges with DEPTH = 8 → level 8, full = 1, overflow = 1; the eight reads return the first eight timestamps in order.
- THRESH = 3, irq_en = 1: `irq` rises one cycle after the third capture and falls one cycle after the pop that brings level to 2.
- Full FIFO with an edge coinciding with a DATA ack → level stays 8, overflow stays 0. Then CTRL write 0x5 → level 0, stickies cleared, enable still 1.
- With `COUNT_CAPTURE_BOTH_EDGES_EN`: a single high pulse pushes 2 entries; STATUS[20] reads 1, then 0 after the first pop.

Source files
------------

// File: rtl/count_capture_pkg.sv
// ---------------------------------------------------------------------------
// count_capture_pkg
// Shared definitions for the count_capture timestamp unit:
//   - Wishbone register select codes (address bits [3:2])
//   - STATUS and CTRL bit positions
//   - width of the FIFO level field reported in STATUS
//   - pack_status(): assembles the STATUS read word
// ---------------------------------------------------------------------------
package count_capture_pkg;

  // Level field is wide enough for DEPTH up to 64 (level may equal DEPTH).
  localparam int LEVEL_W = 7;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_THRESH = 2'd3
  } reg_sel_e;

  // STATUS bit positions (level occupies [LEVEL_W-1:0]).
  localparam int ST_EMPTY     = 16;
  localparam int ST_FULL      = 17;
  localparam int ST_OVERFLOW  = 18;
  localparam int ST_UNDERFLOW = 19;
  localparam int ST_EDGE      = 20;

  // CTRL bit positions.
  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_CLEAR  = 2;

  function automatic logic [31:0] pack_status(
    input logic [LEVEL_W-1:0] level,
    input logic               empty,
    input logic               full,
    input logic               overflow,
    input logic               underflow,
    input logic               head_edge
  );
    logic [31:0] word;
    word                  = '0;
    word[LEVEL_W-1:0]     = level;
    word[ST_EMPTY]        = empty;
    word[ST_FULL]         = full;
    word[ST_OVERFLOW]     = overflow;
    word[ST_UNDERFLOW]    = underflow;
    word[ST_EDGE]         = head_edge;
    return word;
  endfunction

endpackage

// File: rtl/count_capture_fifo.sv
// ---------------------------------------------------------------------------
// capture_fifo
// Synchronous FIFO holding captured timestamps.
// Pointers are log2(DEPTH)+1 bits and wrap naturally; level = wr - rd.
// Ports:
//   clk, srst      : clock, synchronous active-high reset
//   i_push         : write request (dropped when full unless a pop coincides)
//   i_pop          : read request (ignored when empty)
//   i_flush        : empties the FIFO, overriding push and pop
//   i_wr_data      : entry to store
//   o_rd_data      : current head entry (valid when !o_empty)
//   o_empty/o_full : occupancy flags
//   o_level        : number of stored entries
// ---------------------------------------------------------------------------
module capture_fifo
  import count_capture_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic               i_flush,
  input  logic [WIDTH-1:0]   i_wr_data,
  output logic [WIDTH-1:0]   o_rd_data,
  output logic               o_empty,
  output logic               o_full,
  output logic [LEVEL_W-1:0] o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;

  logic [PW-1:0]    w_level;
  logic             w_empty;
  logic             w_full;
  logic             w_do_pop;
  logic             w_do_push;

  assign w_level = r_wr_ptr - r_rd_ptr;
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (w_level == PW'(DEPTH));

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // accepted when it coincides with an effective pop.
  assign w_do_pop  = i_pop & ~w_empty;
  assign w_do_push = i_push & (~w_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (srst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end
  end

  // Head is read asynchronously so the Wishbone data register can capture
  // it on the same edge that advances the read pointer.
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty   = w_empty;
  assign o_full    = w_full;
  assign o_level   = LEVEL_W'(w_level);

endmodule

// File: rtl/count_capture.sv
// ---------------------------------------------------------------------------
// count_capture
// Latches the free-running `count` bus into a FIFO on each synchronized
// edge of `cap_in`; firmware drains timestamps over Wishbone and can take a
// level interrupt when the fill level reaches a programmable threshold.
//
// Optional feature macro: COUNT_CAPTURE_BOTH_EDGES_EN
//   defined   : falling edges also capture; each entry carries an edge flag
//               (1 = rising) reported in STATUS[20] for the head entry.
//   undefined : rising edges only; STATUS[20] reads 0.
//
// Ports:
//   wb_clk_i, wb_rst_i   : clock, synchronous active-high reset
//   wbs_stb_i/cyc_i/we_i : Wishbone strobe, cycle, write enable
//   wbs_sel_i            : byte lanes (lane 0 carries all writable fields)
//   wbs_adr_i            : address, bits [3:2] select the register
//   wbs_dat_i            : write data
//   wbs_ack_o            : one-cycle acknowledge
//   wbs_dat_o            : registered read data, valid during ack
//   count                : live counter value
//   cap_in               : asynchronous trigger
//   irq                  : registered level interrupt
// Registers: 0 DATA (pop), 1 STATUS, 2 CTRL {clear, irq_en, enable},
//            3 THRESH [6:0].
// ---------------------------------------------------------------------------
module count_capture
  import count_capture_pkg::*;
#(
  parameter int BITS  = 32,
  parameter int DEPTH = 8
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  input  logic [BITS-1:0] count,
  input  logic            cap_in,
  output logic            irq
);

`ifdef COUNT_CAPTURE_BOTH_EDGES_EN
  localparam int FIFO_W = BITS + 1;
`else
  localparam int FIFO_W = BITS;
`endif

  // ---------------- trigger synchronizer and edge detect ----------------
  logic r_s1, r_s2, r_s3;
  logic w_rise;
  logic w_edge;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= cap_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise = r_s2 & ~r_s3;

`ifdef COUNT_CAPTURE_BOTH_EDGES_EN
  logic w_fall;
  assign w_fall = ~r_s2 & r_s3;
  assign w_edge = w_rise | w_fall;
`else
  assign w_edge = w_rise;
`endif

  // ---------------- control registers ----------------
  logic               r_enable;
  logic               r_irq_en;
  logic [LEVEL_W-1:0] r_thresh;
  logic               r_overflow;
  logic               r_underflow;
  logic               r_ack;
  logic [31:0]        r_dat;
  logic               r_irq;

  // ---------------- Wishbone decode ----------------
  logic     w_valid;
  logic     w_access;
  logic     w_wr;
  logic     w_rd;
  reg_sel_e w_sel;
  logic     w_pop;
  logic     w_ctrl_wr;
  logic     w_thresh_wr;
  logic     w_clear;

  assign w_valid  = wbs_cyc_i & wbs_stb_i;
  // Only a fresh request is serviced; holding valid across an ack cycle
  // therefore yields ack on alternate cycles, never back to back.
  assign w_access = w_valid & ~r_ack;
  assign w_wr     = w_access & wbs_we_i;
  assign w_rd     = w_access & ~wbs_we_i;
  assign w_sel    = reg_sel_e'(wbs_adr_i[3:2]);

  assign w_pop       = w_rd & (w_sel == REG_DATA);
  assign w_ctrl_wr   = w_wr & (w_sel == REG_CTRL) & wbs_sel_i[0];
  assign w_thresh_wr = w_wr & (w_sel == REG_THRESH) & wbs_sel_i[0];
  assign w_clear     = w_ctrl_wr & wbs_dat_i[CTRL_CLEAR];

  // ---------------- FIFO ----------------
  logic               w_push;
  logic [FIFO_W-1:0]  w_fifo_wdata;
  logic [FIFO_W-1:0]  w_head;
  logic               w_empty;
  logic               w_full;
  logic [LEVEL_W-1:0] w_level;
  logic               w_head_edge;

  assign w_push = r_enable & w_edge;

`ifdef COUNT_CAPTURE_BOTH_EDGES_EN
  assign w_fifo_wdata = {w_rise, count};
  assign w_head_edge  = ~w_empty & w_head[BITS];
`else
  assign w_fifo_wdata = count;
  assign w_head_edge  = 1'b0;
`endif

  capture_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (wb_clk_i),
    .srst      (wb_rst_i),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_flush   (w_clear),
    .i_wr_data (w_fifo_wdata),
    .o_rd_data (w_head),
    .o_empty   (w_empty),
    .o_full    (w_full),
    .o_level   (w_level)
  );

  // ---------------- read mux ----------------
  logic [31:0] w_rd_data;

  always_comb begin
    w_rd_data = '0;
    case (w_sel)
      REG_DATA: begin
        // Empty reads return 0; a same-cycle push is never bypassed.
        if (!w_empty) w_rd_data = 32'(w_head[BITS-1:0]);
      end
      REG_STATUS: begin
        w_rd_data = pack_status(w_level, w_empty, w_full, r_overflow,
                                r_underflow, w_head_edge);
      end
      REG_CTRL: begin
        w_rd_data[CTRL_ENABLE] = r_enable;
        w_rd_data[CTRL_IRQ_EN] = r_irq_en;
      end
      REG_THRESH: begin
        w_rd_data[LEVEL_W-1:0] = r_thresh;
      end
      default: w_rd_data = '0;
    endcase
  end

  // ---------------- state update ----------------
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack       <= 1'b0;
      r_dat       <= '0;
      r_enable    <= 1'b0;
      r_irq_en    <= 1'b0;
      r_thresh    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      r_ack <= w_access;
      if (w_rd) r_dat <= w_rd_data;

      if (w_ctrl_wr) begin
        r_enable <= wbs_dat_i[CTRL_ENABLE];
        r_irq_en <= wbs_dat_i[CTRL_IRQ_EN];
      end
      if (w_thresh_wr) r_thresh <= wbs_dat_i[LEVEL_W-1:0];

      if (w_clear) begin
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
      end else begin
        // When full, a coincident pop makes room, so no entry is lost.
        if (w_push && w_full && !w_pop) r_overflow  <= 1'b1;
        if (w_pop && w_empty)           r_underflow <= 1'b1;
      end

      r_irq <= r_irq_en &
               (((r_thresh != '0) && (w_level >= r_thresh)) | r_overflow);
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign irq       = r_irq;

  // Address/data/lane bits outside the decoded fields are intentionally
  // ignored.
  logic w_unused;
  assign w_unused = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i[31:7],
                      wbs_sel_i[3:1]};

endmodule

// File: tb/tb_count_capture.sv
`timescale 1ns/1ps
// Directed bench for count_capture (BITS = 32, DEPTH = 8).
module tb_count_capture;

  localparam int BITS  = 32;
  localparam int DEPTH = 8;

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;
  localparam logic [1:0] A_THRESH = 2'd3;

  logic            wb_clk_i = 1'b0;
  logic            wb_rst_i = 1'b1;
  logic            wbs_stb_i = 1'b0;
  logic            wbs_cyc_i = 1'b0;
  logic            wbs_we_i = 1'b0;
  logic [3:0]      wbs_sel_i = 4'h0;
  logic [31:0]     wbs_adr_i = '0;
  logic [31:0]     wbs_dat_i = '0;
  logic            wbs_ack_o;
  logic [31:0]     wbs_dat_o;
  logic [BITS-1:0] count = '0;
  logic            cap_in = 1'b0;
  logic            irq;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rdata;
  logic [31:0] c0;

  count_capture #(.BITS(BITS), .DEPTH(DEPTH)) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .count     (count),
    .cap_in    (cap_in),
    .irq       (irq)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Advance one clock; inputs change and outputs are sampled 1 ns after
  // the edge. count increments once per cycle.
  task automatic step();
    @(posedge wb_clk_i);
    #1;
    count = count + 1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Returns with ack high (the ack cycle); request is withdrawn on return.
  task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
    wbs_adr_i = {28'd0, a, 2'b00};
    wbs_we_i  = 1'b0;
    wbs_sel_i = 4'hf;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    for (int n = 0; n < 16; n++) begin
      step();
      if (wbs_ack_o === 1'b1) break;
    end
    check("rd_ack", {31'd0, wbs_ack_o}, 32'd1);
    d = wbs_dat_o;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    $display("txn rd reg=%0d data=%h", a, d);
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
    wbs_adr_i = {28'd0, a, 2'b00};
    wbs_dat_i = d;
    wbs_we_i  = 1'b1;
    wbs_sel_i = 4'hf;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    for (int n = 0; n < 16; n++) begin
      step();
      if (wbs_ack_o === 1'b1) break;
    end
    check("wr_ack", {31'd0, wbs_ack_o}, 32'd1);
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    $display("txn wr reg=%0d data=%h", a, d);
    step();
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a,
                        input logic [31:0] expv);
    logic [31:0] d;
    wb_read(a, d);
    check(tag, d, expv);
    step();
  endtask

  // One-cycle-high, one-cycle-low trigger pulse; the timestamp stored is
  // the count two edges after the one that first sees cap_in high.
  task automatic pulse();
    exp_q.push_back(count + 2);
    cap_in = 1'b1;
    step();
    cap_in = 1'b0;
    step();
  endtask

  initial begin
    // ---------------- reset ----------------
    wb_rst_i = 1'b1;
    step();
    step();
    check("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
    check("rst_dat", wbs_dat_o, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    wb_rst_i = 1'b0;
    step();

    rd_chk("status_reset", A_STATUS, 32'h0001_0000);
    rd_chk("data_empty", A_DATA, 32'h0000_0000);
    rd_chk("status_underflow", A_STATUS, 32'h0009_0000);

    // enable + clear stickies
    wb_write(A_CTRL, 32'h5);
    rd_chk("ctrl_readback", A_CTRL, 32'h0000_0001);
    rd_chk("status_cleared", A_STATUS, 32'h0001_0000);

`ifndef COUNT_CAPTURE_BOTH_EDGES_EN
    // ---------------- single capture at count = 0x100 ----------------
    count = 32'h100;
    cap_in = 1'b1;
    step();
    cap_in = 1'b0;
    step(); step(); step();
    rd_chk("status_level1", A_STATUS, 32'h0000_0001);
    rd_chk("data_first", A_DATA, 32'h0000_0102);
    rd_chk("status_level0", A_STATUS, 32'h0001_0000);

    // ---------------- ten edges into depth 8 ----------------
    exp_q.delete();
    for (int i = 0; i < 10; i++) pulse();
    step(); step(); step();
    rd_chk("status_full_ovf", A_STATUS, 32'h0006_0008);
    for (int i = 0; i < DEPTH; i++) rd_chk("data_order", A_DATA, exp_q[i]);
    rd_chk("status_drained", A_STATUS, 32'h0005_0000);

    // ---------------- threshold interrupt ----------------
    wb_write(A_THRESH, 32'd3);
    rd_chk("thresh_readback", A_THRESH, 32'd3);
    wb_write(A_CTRL, 32'h7);
    check("irq_idle", {31'd0, irq}, 32'd0);
    exp_q.delete();
    pulse();
    pulse();
    exp_q.push_back(count + 2);
    cap_in = 1'b1;
    step();
    cap_in = 1'b0;
    step();
    step();
    check("irq_before", {31'd0, irq}, 32'd0);
    step();
    check("irq_rise", {31'd0, irq}, 32'd1);
    wb_read(A_DATA, rdata);
    check("irq_data", rdata, exp_q[0]);
    check("irq_hold", {31'd0, irq}, 32'd1);
    step();
    check("irq_fall", {31'd0, irq}, 32'd0);
    wb_write(A_CTRL, 32'h5);

    // ---------------- full FIFO: edge coinciding with pop ----------------
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) pulse();
    step(); step(); step();
    rd_chk("status_full", A_STATUS, 32'h0002_0008);
    exp_q.push_back(count + 2);
    cap_in = 1'b1;
    step();
    cap_in = 1'b0;
    step();
    wb_read(A_DATA, rdata);   // ack edge coincides with the push
    check("coinc_data", rdata, exp_q[0]);
    step(); step();
    rd_chk("status_coinc", A_STATUS, 32'h0002_0008);
    wb_write(A_CTRL, 32'h5);
    rd_chk("status_after_clear", A_STATUS, 32'h0001_0000);
    rd_chk("ctrl_after_clear", A_CTRL, 32'h0000_0001);

    // ---------------- push and pop together while empty ----------------
    c0 = count + 2;
    cap_in = 1'b1;
    step();
    cap_in = 1'b0;
    step();
    wb_read(A_DATA, rdata);
    check("empty_coinc_data", rdata, 32'h0);
    step();
    rd_chk("status_empty_coinc", A_STATUS, 32'h0008_0001);
    rd_chk("data_after_coinc", A_DATA, c0);
`else
    // ---------------- both edges: one pulse gives two entries ----------
    c0 = count;
    cap_in = 1'b1;
    step();
    cap_in = 1'b0;
    step(); step(); step(); step(); step();
    rd_chk("status_two_rise", A_STATUS, 32'h0010_0002);
    rd_chk("data_rise", A_DATA, c0 + 32'd2);
    rd_chk("status_one_fall", A_STATUS, 32'h0000_0001);
    rd_chk("data_fall", A_DATA, c0 + 32'd3);
    rd_chk("status_both_empty", A_STATUS, 32'h0001_0000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
